// File: rtl/predict_pkg.sv
// Shared predictor types: 2-bit saturating counter and its step function.
package predict_pkg;

   typedef logic [1:0] bht_ctr_t;

   localparam bht_ctr_t CTR_STRONG_NT = 2'b00;
   localparam bht_ctr_t CTR_WEAK_NT   = 2'b01;
   localparam bht_ctr_t CTR_STRONG_T  = 2'b11;

   function automatic bht_ctr_t ctr_next(
      input bht_ctr_t ctr,
      input logic     taken
   );
      bht_ctr_t nxt;
      nxt = ctr;
      if (taken && (ctr != CTR_STRONG_T))
         nxt = ctr + 2'd1;
      else if (!taken && (ctr != CTR_STRONG_NT))
         nxt = ctr - 2'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/branch_predictor_bht.sv
// Branch history table: async read, sync saturating write, async clear.
module bht
   import predict_pkg::*;
#(
   parameter int INDEX_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INDEX_W-1:0] rd_idx,
   output bht_ctr_t           rd_ctr,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_idx,
   input  logic               wr_taken
);

   localparam int DEPTH = 1 << INDEX_W;

   bht_ctr_t ctr_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            ctr_q[i] <= CTR_WEAK_NT;
      end else if (wr_en) begin
         ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken);
      end
   end

   assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage direction predictor; gshare hashing when
// BRANCH_PREDICTOR_GSHARE_EN is defined, bimodal otherwise.
module branch_predictor
   import predict_pkg::*;
#(
   parameter int INDEX_W = 6,
   parameter int HIST_W  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic [31:0]       pc,
   input  logic [31:0]       pc_plus_4,
   input  logic [31:0]       pc_next,
   input  logic              is_branch,
   input  logic              is_jump,
   output logic [31:0]       pred_pc,
   output logic              pred_taken,
   output logic [HIST_W-1:0] pred_ghr,
   input  logic              upd_en,
   input  logic [31:0]       upd_pc,
   input  logic              upd_taken,
   input  logic              upd_pred_taken,
   input  logic [HIST_W-1:0] upd_ghr,
   input  logic [31:0]       upd_target,
   input  logic [31:0]       upd_pc_plus_4,
   output logic              mispredict,
   output logic [31:0]       redirect_pc
);

   logic [INDEX_W-1:0] rd_idx;
   logic [INDEX_W-1:0] wr_idx;
   bht_ctr_t           rd_ctr;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
   logic [HIST_W-1:0] ghr;

   always_comb begin
      rd_idx = pc[INDEX_W+1:2];
      wr_idx = upd_pc[INDEX_W+1:2];
      rd_idx[HIST_W-1:0] = rd_idx[HIST_W-1:0] ^ ghr;
      wr_idx[HIST_W-1:0] = wr_idx[HIST_W-1:0] ^ upd_ghr;
   end

   // Recovery from execute wins over the speculative shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ghr <= '0;
      else if (mispredict)
         ghr <= {upd_ghr[HIST_W-2:0], upd_taken};
      else if (is_branch && !stall)
         ghr <= {ghr[HIST_W-2:0], pred_taken};
   end

   assign pred_ghr = ghr;

   logic unused;
   assign unused = ^{pc[31:INDEX_W+2], pc[1:0],
                     upd_pc[31:INDEX_W+2], upd_pc[1:0],
                     rd_ctr[0]};
`else
   assign rd_idx   = pc[INDEX_W+1:2];
   assign wr_idx   = upd_pc[INDEX_W+1:2];
   assign pred_ghr = '0;

   logic unused;
   assign unused = ^{pc[31:INDEX_W+2], pc[1:0],
                     upd_pc[31:INDEX_W+2], upd_pc[1:0],
                     rd_ctr[0], upd_ghr, stall};
`endif

   bht #(
      .INDEX_W (INDEX_W)
   ) u_bht (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (rd_idx),
      .rd_ctr   (rd_ctr),
      .wr_en    (upd_en),
      .wr_idx   (wr_idx),
      .wr_taken (upd_taken)
   );

   assign pred_taken  = is_jump | (is_branch & rd_ctr[1]);
   assign pred_pc     = pred_taken ? pc_next : pc_plus_4;
   assign mispredict  = upd_en & (upd_taken != upd_pred_taken);
   assign redirect_pc = upd_taken ? upd_target : upd_pc_plus_4;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic direction predictor in the fetch stage of the pipelined MIPS core. It consumes the fetch-stage predecode results (`pc_plus_4`, `pc_next`, `is_branch`, `is_jump`) and chooses the predicted fetch PC for the next cycle. It keeps a table of 2-bit saturating counters that is trained by branch resolutions from execute. On a misprediction it drives the redirect PC.

## Interface
Parameters:
- `INDEX_W`, 6: log2 of the counter table depth (64 entries).
- `HIST_W`, 6: global history length, ≤ `INDEX_W`; used only with `GSHARE_EN`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: fetch stall; no speculative state changes while high.
- `pc` in 32: fetch PC.
- `pc_plus_4` in 32: fallthrough PC from predecode.
- `pc_next` in 32: decoded branch/jump target from predecode.
- `is_branch` in 1: fetched instruction is `beq`/`bne`.
- `is_jump` in 1: fetched instruction is `j`/`jal`.
- `pred_pc` out 32: predicted next fetch PC.
- `pred_taken` out 1: direction prediction; carried down the pipe.
- `pred_ghr` out `HIST_W`: history snapshot used for this prediction; carried down the pipe (0 without `GSHARE_EN`).
- `upd_en` in 1: execute resolves a conditional branch this cycle.
- `upd_pc` in 32: PC of the resolved branch.
- `upd_taken` in 1: actual outcome.
- `upd_pred_taken` in 1: prediction that was made for it.
- `upd_ghr` in `HIST_W`: snapshot carried with it.
- `upd_target` in 32: resolved taken target.
- `upd_pc_plus_4` in 32: resolved fallthrough.
- `mispredict` out 1: redirect request; flush younger stages.
- `redirect_pc` out 32: correct PC when `mispredict` is high.

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. The prediction is bit[1].
- Read index is `pc[INDEX_W+1:2]`. With `GSHARE_EN`, the low `HIST_W` bits are XORed with `ghr`.
- `pred_taken` = `is_jump | (is_branch & ctr[idx][1])`.
- `pred_pc` = `pred_taken ? pc_next : pc_plus_4`.
- Update: when `upd_en`, the counter at the index recomputed from `upd_pc` and `upd_ghr` moves toward `upd_taken`. It saturates at 00 and 11; there is no wrap.
- `mispredict` = `upd_en & (upd_taken != upd_pred_taken)`.
- `redirect_pc` = `upd_taken ? upd_target : upd_pc_plus_4`. Outside a mispredict it is don't-care but is driven by the same expression.
- Jumps never touch the table or the history.
- Reset values:
  - All counters are 01.
  - `ghr` is 0.
  - Outputs follow combinationally from the inputs and reset state: `mispredict` is 0 when `upd_en` is 0, and `pred_pc` = `pc_plus_4` for a non-jump instruction.

## Timing
- Prediction is combinational, same cycle as predecode. The table read is asynchronous.
- A table write takes effect at the next rising edge. A read of the same entry in the update cycle returns the old value; there is no bypass.
- `mispredict` and `redirect_pc` are combinational from the `upd_*` inputs. The PC mux gives `redirect_pc` priority over `pred_pc`.
- Simultaneous events: an update and a prediction in the same cycle on different or identical entries both proceed. The update writes and the prediction reads the pre-write value.
- Reset asserted mid-operation clears the table and history immediately, independent of the clock.

## Configuration
- `BRANCH_PREDICTOR_GSHARE_EN` defined:
  - A `HIST_W`-bit global history register is present and the table index is XOR-hashed with it.
  - When `is_branch & ~stall & ~mispredict`, the history shifts left and takes `pred_taken` in at bit 0 (speculative update).
  - On `mispredict`, the history is set to `{upd_ghr[HIST_W-2:0], upd_taken}`. This overrides any same-cycle speculative shift.
  - `pred_ghr` outputs the current history.
- Undefined: plain bimodal predictor. There is no history register, `pred_ghr` is tied to 0 and `upd_ghr` is ignored.

## Structure
- The shared package `predict_pkg` holds:
  - typedef `bht_ctr_t` (2-bit);
  - constants `CTR_WEAK_NT` (2'b01) and `CTR_STRONG_T` (2'b11);
  - function `ctr_next(ctr, taken)` for the saturating step.
- Sub-module `bht`: the counter array with asynchronous read, synchronous write and async-low clear, parameterised by `INDEX_W`. Index hashing, history, and PC selection stay in `branch_predictor`.

## Test plan
- Reset then `pc`=0x0040_0000, `is_branch`=1, `pc_next`=0x0040_0020 -> `pred_taken`=0, `pred_pc`=0x0040_0004.
- Two taken updates on `upd_pc`=0x0040_0000 (prediction 0, then 1) -> the first cycle gives `mispredict`=1 and `redirect_pc`=`upd_target`. The next read predicts taken, `pred_pc`=0x0040_0020. Four more taken updates leave the counter at 11, with no wrap.
- `is_jump`=1, `pc_next`=0x0040_1000 in a fresh table -> `pred_pc`=0x0040_1000 and the table is unchanged.
- Update and read of the same entry in one cycle (counter 01, `upd_taken`=1) -> the read gives not-taken; the next cycle gives taken.
- `BRANCH_PREDICTOR_GSHARE_EN`, `HIST_W`=6: three predicted-not-taken branches, then `mispredict` with `upd_ghr`=6'b000001 and `upd_taken`=1 -> history becomes 6'b000011. A same-cycle `is_branch` does not shift it.
- Assert `rst_n` low mid-stream with trained entries -> all entries read weak-NT immediately, and `ghr`=0.
